ballot_tally: RTL

BALLOT_TALLY -- requirements
Module: ballot_tally

---
 rtl/ballot_pkg.sv | 14 +
 rtl/ballot_debounce.sv | 36 +++
 rtl/ballot_tally.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/ballot_pkg.sv
// Shared types and defaults for the ballot tally block.
package ballot_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int DEF_DEBOUNCE_CYC = 100;
  localparam int DEF_CNT_W        = 8;
  localparam int DEB_W            = 16;

endpackage

// File: rtl/ballot_debounce.sv
// One candidate channel: counts consecutive high cycles and emits a single
// qualify pulse per press when the count reaches DEBOUNCE_CYC.
module ballot_debounce
  import ballot_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
  input  logic clock,
  input  logic reset_n,
  input  logic button,
  output logic qualify
);

  localparam logic [DEB_W-1:0] LIMIT = DEB_W'(DEBOUNCE_CYC);
  localparam logic [DEB_W-1:0] LAST  = DEB_W'(DEBOUNCE_CYC - 1);

  logic [DEB_W-1:0] hold_r;

  // Hold counter saturates at LIMIT so a long press produces only one pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_r  <= {DEB_W{1'b0}};
      qualify <= 1'b0;
    end else begin
      qualify <= button && (hold_r == LAST);
      if (!button) begin
        hold_r <= {DEB_W{1'b0}};
      end else if (hold_r != LIMIT) begin
        hold_r <= hold_r + 16'd1;
      end else begin
        hold_r <= hold_r;
      end
    end
  end

endmodule

// File: rtl/ballot_tally.sv
// Electronic ballot tally: debounced candidate buttons, one vote per armed
// ballot, saturating per-candidate and total counters, and result readout.
module ballot_tally
  import ballot_pkg::*;
#(
  parameter  int NUM_CAND     = 4,
  parameter  int CNT_W        = DEF_CNT_W,
  parameter  int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  localparam int SEL_W        = ($clog2(NUM_CAND) < 1) ? 1 : $clog2(NUM_CAND),
  localparam int TOT_W        = CNT_W + SEL_W
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                mode,
  input  logic                arm,
  input  logic [NUM_CAND-1:0] button,
  input  logic [SEL_W-1:0]    sel,
  output logic                ready,
  output logic                vote_ack,
  output logic                vote_err,
  output logic [CNT_W-1:0]    count_out,
  output logic [TOT_W-1:0]    total_out,
  output logic [SEL_W-1:0]    winner,
  output logic                tie,
  output logic                sat
);

  localparam logic [NUM_CAND-1:0] ONE = NUM_CAND'(1);

  logic [NUM_CAND-1:0] qual;
  state_t              state_r;
  logic [CNT_W-1:0]    cnt_r [NUM_CAND];
  logic                single_s;
  logic                multi_s;
  logic [SEL_W-1:0]    pick_s;
  logic [CNT_W-1:0]    rd_s;
  logic [CNT_W-1:0]    best_s;
  logic [SEL_W-1:0]    win_s;
  logic                tie_s;

  for (genvar g = 0; g < NUM_CAND; g++) begin : g_deb
    ballot_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb (
      .clock   (clock),
      .reset_n (reset_n),
      .button  (button[g]),
      .qualify (qual[g])
    );
  end

  // Classify this cycle's qualify pulses: none, exactly one, or several.
  always_comb begin
    single_s = (qual != '0) && ((qual & (qual - ONE)) == '0);
    multi_s  = (qual != '0) && !single_s;
    pick_s   = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (qual[i]) begin
        pick_s = SEL_W'(i);
      end else begin
        pick_s = pick_s;
      end
    end
  end

  // Ballot FSM with vote counters; readout mode cancels any open ballot.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      ready     <= 1'b0;
      vote_ack  <= 1'b0;
      vote_err  <= 1'b0;
      total_out <= '0;
      sat       <= 1'b0;
      for (int i = 0; i < NUM_CAND; i++) cnt_r[i] <= '0;
    end else begin
      vote_ack <= 1'b0;
      vote_err <= 1'b0;
      if (mode) begin
        state_r <= IDLE;
        ready   <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            if (arm) begin
              state_r <= ARMED;
              ready   <= 1'b1;
            end
          end
          ARMED: begin
            if (single_s) begin
              if (cnt_r[pick_s] == '1) sat <= 1'b1;
              else cnt_r[pick_s] <= cnt_r[pick_s] + CNT_W'(1);
              if (total_out == '1) sat <= 1'b1;
              else total_out <= total_out + TOT_W'(1);
              vote_ack <= 1'b1;
              state_r  <= LOCKED;
              ready    <= 1'b0;
            end else if (multi_s) begin
              vote_err <= 1'b1;
              state_r  <= LOCKED;
              ready    <= 1'b0;
            end
          end
          LOCKED: begin
            if (button == '0) state_r <= IDLE;
          end
          default: begin
            state_r <= IDLE;
            ready   <= 1'b0;
          end
        endcase
      end
    end
  end

  // Readout mux (unpopulated indices read 0) and lowest-index leader search.
  always_comb begin
    rd_s   = '0;
    best_s = '0;
    win_s  = '0;
    tie_s  = 1'b0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (sel == SEL_W'(i)) rd_s = cnt_r[i];
      if (cnt_r[i] > best_s) begin
        best_s = cnt_r[i];
        win_s  = SEL_W'(i);
        tie_s  = 1'b0;
      end else if ((cnt_r[i] == best_s) && (best_s != '0)) begin
        tie_s = 1'b1;
      end else begin
        tie_s = tie_s;
      end
    end
  end

  // Registered readout and leader outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_out <= '0;
      winner    <= '0;
      tie       <= 1'b0;
    end else begin
      count_out <= rd_s;
      winner    <= win_s;
      tie       <= tie_s;
    end
  end

endmodule
